muldiv_ctrl: RTL and testbench

//   Sequences HI/LO instructions from the EX stage: MULT/MULTU, DIV/DIVU, MTHI/MTLO and MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_ctrl_hilo_regs.sv | 37 +++
 rtl/muldiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO sequencer: op codes, FSM states and the datapath width.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int OP_W  = 4;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO storage: independent write enables, one 64-bit write port {hi, lo}.
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 hi_we,
    input  logic                 lo_we,
    input  logic [2*WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we) hi_d = wdata[2*WIDTH-1:WIDTH];
        if (lo_we) lo_d = wdata[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO instruction sequencer: single-cycle multiplies, stalled iterative divides, HI/LO ownership.
// Optional build macro MULDIV_DIV0_FASTPATH_EN: zero-divisor divides bypass the divider.
module muldiv_ctrl #(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int OP_W  = muldiv_pkg::OP_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    input  logic              flush,
    output logic              stall,
    output logic [WIDTH-1:0]  mf_result,
    output logic [WIDTH-1:0]  hi_out,
    output logic [WIDTH-1:0]  lo_out,
    output logic              div_start,
    output logic              div_signed,
    output logic [WIDTH-1:0]  div_dividend,
    output logic [WIDTH-1:0]  div_divisor,
    input  logic              div_done,
    input  logic [WIDTH-1:0]  div_quotient,
    input  logic [WIDTH-1:0]  div_remainder
);

    import muldiv_pkg::*;

    state_e             state_q, state_d;
    logic               div_signed_q, div_signed_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;

    logic               hi_we, lo_we;
    logic [2*WIDTH-1:0] hilo_wdata;
    logic [WIDTH-1:0]   hi, lo;

    logic [2*WIDTH-1:0] mul_a, mul_b, product;
    logic               div_zero;

    // Extending both operands to 64 bits makes the truncated product correct for MULT and MULTU.
    always_comb begin
        if (op == OP_MULT) begin
            mul_a = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
            mul_b = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
        end else begin
            mul_a = {{WIDTH{1'b0}}, rs_val};
            mul_b = {{WIDTH{1'b0}}, rt_val};
        end
        product = mul_a * mul_b;
    end

`ifdef MULDIV_DIV0_FASTPATH_EN
    assign div_zero = (rt_val == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        div_signed_d = div_signed_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        stall        = 1'b0;
        div_start    = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hilo_wdata   = product;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            hi_we = 1'b1;
                            lo_we = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_we      = 1'b1;
                            hilo_wdata = {rs_val, rs_val};
                        end
                        OP_MTLO: begin
                            lo_we      = 1'b1;
                            hilo_wdata = {rs_val, rs_val};
                        end
                        OP_DIV, OP_DIVU: begin
                            if (div_zero) begin
                                hi_we      = 1'b1;
                                lo_we      = 1'b1;
                                hilo_wdata = {rs_val, {WIDTH{1'b1}}};
                            end else begin
                                stall        = 1'b1;
                                div_signed_d = (op == OP_DIV);
                                dividend_d   = rs_val;
                                divisor_d    = rt_val;
                                state_d      = ST_LAUNCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LAUNCH: begin
                // The pulse goes out even when flushed, so the divider must then be drained.
                stall     = 1'b1;
                div_start = 1'b1;
                state_d   = flush ? ST_DRAIN : ST_BUSY;
            end
            ST_BUSY: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        hi_we      = 1'b1;
                        lo_we      = 1'b1;
                        hilo_wdata = {div_remainder, div_quotient};
                    end
                end else begin
                    stall = 1'b1;
                    if (flush) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stall = op_valid && (op != OP_NONE);
                if (div_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
        end else begin
            state_q      <= state_d;
            div_signed_q <= div_signed_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
        end
    end

    hilo_regs #(
        .WIDTH (WIDTH)
    ) u_hilo_regs (
        .clk    (clk),
        .resetn (resetn),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (hilo_wdata),
        .hi     (hi),
        .lo     (lo)
    );

    assign mf_result    = (op == OP_MFHI) ? hi : lo;
    assign hi_out       = hi;
    assign lo_out       = lo;
    assign div_signed   = div_signed_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a fixed-latency behavioural divider that has no reset.
module tb_muldiv_ctrl;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam int         DIV_LAT  = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] mf_result, hi_out, lo_out;
    logic        div_start, div_signed;
    logic [31:0] div_dividend, div_divisor;
    logic        div_done = 1'b0;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .op_valid      (op_valid),
        .op            (op),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .flush         (flush),
        .stall         (stall),
        .mf_result     (mf_result),
        .hi_out        (hi_out),
        .lo_out        (lo_out),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Divider model: result appears DIV_LAT edges after the start pulse is sampled.
    int          m_cnt = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_sg = 1'b0;
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_done <= 1'b1;
                if (m_sg) begin
                    div_quotient  <= $signed(m_a) / $signed(m_b);
                    div_remainder <= $signed(m_a) % $signed(m_b);
                end else begin
                    div_quotient  <= m_a / m_b;
                    div_remainder <= m_a % m_b;
                end
            end
        end
        if (div_start) begin
            m_cnt <= DIV_LAT;
            m_a   <= div_dividend;
            m_b   <= div_divisor;
            m_sg  <= div_signed;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a divide and hold it in EX until the stall drops; returns stall-cycle count.
    task automatic run_div(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, output int cyc);
        int starts;
        starts = 0;
        cyc = 0;
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        #1;
        while (stall && cyc < 50) begin
            if (div_start) begin
                starts++;
                chk({tag, "_signed"}, div_signed, (o == OP_DIV));
                chk({tag, "_dividend"}, div_dividend, a);
                chk({tag, "_divisor"}, div_divisor, b);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_stall_bounded"}, (cyc < 50), 1'b1);
        if (div_start) starts++;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = OP_NONE;
        chk({tag, "_start_pulses"}, starts, 1);
    endtask

    initial begin
        int cyc;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_signed", div_signed, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        resetn = 1'b1;
        tick();

        // DIVU 0x200/0x100
        run_div("divu1", OP_DIVU, 32'h200, 32'h100, cyc);
        chk("divu1_latency", cyc, 2 + DIV_LAT);
        chk("divu1_lo", lo_out, 32'h2);
        chk("divu1_hi", hi_out, 32'h0);
        op_valid = 1'b1; op = OP_MFLO; #1;
        chk("mflo_result", mf_result, 32'h2);
        chk("mflo_stall", stall, 0);
        tick();
        op = OP_MFHI; #1;
        chk("mfhi_result", mf_result, 32'h0);
        chk("mfhi_stall", stall, 0);
        tick();
        op_valid = 1'b0; op = OP_NONE;

        // Signed divides
        run_div("div2", OP_DIV, 32'hFFFFFE00, 32'h00000100, cyc);
        chk("div2_lo", lo_out, 32'hFFFFFFFE);
        chk("div2_hi", hi_out, 32'h0);
        run_div("div3", OP_DIV, 32'hEEBAEBE7, 32'hE67EF001, cyc);
        chk("div3_lo", lo_out, 32'h0);
        chk("div3_hi", hi_out, 32'hEEBAEBE7);

        // Multiplies: one cycle, no stall
        op_valid = 1'b1; op = OP_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'h2; #1;
        chk("multu_stall", stall, 0);
        chk("multu_start", div_start, 0);
        tick();
        chk("multu_hi", hi_out, 32'h1);
        chk("multu_lo", lo_out, 32'hFFFFFFFE);
        op = OP_MULT; #1;
        chk("mult_stall", stall, 0);
        tick();
        chk("mult_hi", hi_out, 32'hFFFFFFFF);
        chk("mult_lo", lo_out, 32'hFFFFFFFE);

        // MTHI, then a DIVU flushed in BUSY, then MULTU held during DRAIN
        op = OP_MTHI; rs_val = 32'h1234; #1;
        chk("mthi_stall", stall, 0);
        tick();
        chk("mthi_hi", hi_out, 32'h1234);
        op = OP_DIVU; rs_val = 32'd10; rt_val = 32'd3;
        tick();
        chk("fl_launch_start", div_start, 1);
        tick();
        flush = 1'b1; op_valid = 1'b0;
        tick();
        flush = 1'b0;
        op_valid = 1'b1; op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd4; #1;
        cyc = 0;
        while (stall && cyc < 20) begin
            chk("fl_drain_hi", hi_out, 32'h1234);
            tick();
            cyc++;
        end
        chk("fl_drain_cycles", cyc, DIV_LAT);
        chk("fl_hi_kept", hi_out, 32'h1234);
        chk("fl_lo_kept", lo_out, 32'hFFFFFFFE);
        tick();
        chk("fl_multu_hi", hi_out, 32'h0);
        chk("fl_multu_lo", lo_out, 32'hC);

        // Async reset mid-BUSY; the stale div_done that follows must be ignored
        op = OP_MTLO; rs_val = 32'h55;
        tick();
        chk("mtlo_lo", lo_out, 32'h55);
        op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        tick();
        #2;
        resetn = 1'b0; op_valid = 1'b0; op = OP_NONE;
        #1;
        chk("ar_hi", hi_out, 0);
        chk("ar_lo", lo_out, 0);
        chk("ar_stall", stall, 0);
        chk("ar_div_start", div_start, 0);
        chk("ar_dividend", div_dividend, 0);
        tick();
        resetn = 1'b1;
        repeat (5) begin
            tick();
            chk("ar_stale_hi", hi_out, 0);
            chk("ar_stale_lo", lo_out, 0);
        end
        op_valid = 1'b1; op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd6; #1;
        chk("ar_multu_stall", stall, 0);
        tick();
        chk("ar_multu_lo", lo_out, 32'd30);
        op_valid = 1'b0; op = OP_NONE;

`ifdef MULDIV_DIV0_FASTPATH_EN
        op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd7; rt_val = 32'd0; #1;
        chk("d0_stall", stall, 0);
        chk("d0_start", div_start, 0);
        tick();
        op_valid = 1'b0; op = OP_NONE; #1;
        chk("d0_start_after", div_start, 0);
        chk("d0_hi", hi_out, 32'h7);
        chk("d0_lo", lo_out, 32'hFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish required finish");
        $fatal(1);
    end

endmodule
